floating_point_adder: RTL and testbench



---
 rtl/floating_point_adder.sv | 192 +++++++++++++++++++
 tb/tb_floating_point_adder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/floating_point_adder.sv
// Multi-cycle IEEE-754 single-precision adder (flush-to-zero, truncating); one result per pass, 3..~52 cycles.
// No backpressure: free-running, captures x/y whenever idle and flags each result with a one-cycle valid.
module floating_point_adder (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] sum,
  output logic        valid,
  output logic        overflow
);

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, PACK} state_t;
  state_t state, state_nxt;

  logic [31:0]       xa, ya;
  logic              sa, sb;
  logic [7:0]        ea, eb;
  logic [23:0]       ma, mb;
  logic              rs;
  logic signed [9:0] re;
  logic [24:0]       rm;
  logic              byp;
  logic [31:0]       byp_dat;

  logic xa_nan, ya_nan, xa_inf, ya_inf, xa_zero, ya_zero;
  assign xa_nan  = (xa[30:23] == 8'hFF) && (xa[22:0] != 23'd0);
  assign ya_nan  = (ya[30:23] == 8'hFF) && (ya[22:0] != 23'd0);
  assign xa_inf  = (xa[30:23] == 8'hFF) && (xa[22:0] == 23'd0);
  assign ya_inf  = (ya[30:23] == 8'hFF) && (ya[22:0] == 23'd0);
  assign xa_zero = (xa[30:23] == 8'h00);
  assign ya_zero = (ya[30:23] == 8'h00);

  // Special operands resolve straight to a packed word, skipping the datapath
  logic        special;
  logic [31:0] special_dat;
  always_comb begin
    special     = 1'b1;
    special_dat = 32'h0000_0000;
    if (xa_nan || ya_nan || (xa_inf && ya_inf && (xa[31] != ya[31])))
      special_dat = 32'h7FC0_0000;
    else if (xa_inf)
      special_dat = xa;
    else if (ya_inf)
      special_dat = ya;
    else if (xa_zero && ya_zero)
      special_dat = 32'h0000_0000;
    else if (xa_zero)
      special_dat = ya;
    else if (ya_zero)
      special_dat = xa;
    else
      special = 1'b0;
  end

  logic       a_big;
  logic [7:0] exp_diff;
  logic       too_far;
  assign a_big    = (ea > eb);
  assign exp_diff = a_big ? (ea - eb) : (eb - ea);
  assign too_far  = (exp_diff > 8'd24);

  logic        a_ge;
  logic        cancel;
  logic [24:0] mag_add, mag_sub;
  assign a_ge    = (ma >= mb);
  assign cancel  = (sa != sb) && (ma == mb);
  assign mag_add = {1'b0, ma} + {1'b0, mb};
  assign mag_sub = a_ge ? ({1'b0, ma} - {1'b0, mb}) : ({1'b0, mb} - {1'b0, ma});

  logic signed [9:0] re_dec;
  assign re_dec = re - 10'sd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   state_nxt = UNPACK;
      UNPACK: state_nxt = special ? PACK : ALIGN;
      ALIGN: begin
        if (ea == eb)   state_nxt = ADD;
        else if (too_far) state_nxt = PACK;
      end
      ADD:    state_nxt = cancel ? PACK : NORM;
      NORM: begin
        if (rm[24] || rm[23])     state_nxt = PACK;
        else if (re_dec <= 10'sd0) state_nxt = PACK;
      end
      PACK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xa       <= 32'd0;
      ya       <= 32'd0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      ea       <= 8'd0;
      eb       <= 8'd0;
      ma       <= 24'd0;
      mb       <= 24'd0;
      rs       <= 1'b0;
      re       <= 10'sd0;
      rm       <= 25'd0;
      byp      <= 1'b0;
      byp_dat  <= 32'd0;
      sum      <= 32'd0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          xa  <= x;
          ya  <= y;
          byp <= 1'b0;
        end
        UNPACK: begin
          sa      <= xa[31];
          sb      <= ya[31];
          ea      <= xa[30:23];
          eb      <= ya[30:23];
          ma      <= {1'b1, xa[22:0]};
          mb      <= {1'b1, ya[22:0]};
          byp     <= special;
          byp_dat <= special_dat;
        end
        ALIGN: begin
          if (ea != eb) begin
            if (too_far) begin
              byp     <= 1'b1;
              byp_dat <= a_big ? xa : ya;
            end else if (a_big) begin
              mb <= mb >> 1;
              eb <= eb + 8'd1;
            end else begin
              ma <= ma >> 1;
              ea <= ea + 8'd1;
            end
          end
        end
        ADD: begin
          re <= $signed({2'b00, ea});
          if (cancel) begin
            byp     <= 1'b1;
            byp_dat <= 32'h0000_0000;
          end else if (sa == sb) begin
            rs <= sa;
            rm <= mag_add;
          end else begin
            rs <= a_ge ? sa : sb;
            rm <= mag_sub;
          end
        end
        NORM: begin
          if (rm[24]) begin
            rm <= rm >> 1;
            re <= re + 10'sd1;
          end else if (!rm[23]) begin
            rm <= rm << 1;
            re <= re_dec;
            if (re_dec <= 10'sd0) begin
              byp     <= 1'b1;
              byp_dat <= 32'h0000_0000;
            end
          end
        end
        PACK: begin
          valid <= 1'b1;
          if (byp) begin
            sum      <= byp_dat;
            overflow <= 1'b0;
          end else if (re >= 10'sd255) begin
            sum      <= {rs, 8'hFF, 23'd0};
            overflow <= 1'b1;
          end else begin
            sum      <= {rs, re[7:0], rm[22:0]};
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_floating_point_adder.sv
// Directed-vector bench for floating_point_adder: arithmetic reference model, per-cycle output checker,
// literal expectations that pin the model, and a mid-operation reset abort.
module tb_floating_point_adder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] x = 32'd0;
  logic [31:0] y = 32'd0;
  logic [31:0] sum;
  logic        valid;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  logic [32:0] expq[$];
  logic [31:0] last_sum = 32'd0;
  logic        last_ovf = 1'b0;

  localparam int N = 14;
  logic [31:0] va[N];
  logic [31:0] vb[N];
  logic [32:0] ve[N];

  floating_point_adder dut (
    .clk(clk),
    .reset(reset),
    .x(x),
    .y(y),
    .sum(sum),
    .valid(valid),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Returns {overflow, sum} from plain integer arithmetic on the decoded operands
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big, sml;
    int          eb_i, es_i, d, e;
    longint      mbig, msml, m;
    logic        s;
    logic        a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) return {1'b0, 32'h7FC00000};
    if (a_inf) return {1'b0, a};
    if (b_inf) return {1'b0, b};
    if (a[30:23] == 0 && b[30:23] == 0) return 33'd0;
    if (a[30:23] == 0) return {1'b0, b};
    if (b[30:23] == 0) return {1'b0, a};
    if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    eb_i = int'(big[30:23]);
    es_i = int'(sml[30:23]);
    d = eb_i - es_i;
    if (d > 24) return {1'b0, big};
    mbig = longint'({1'b1, big[22:0]});
    msml = longint'({1'b1, sml[22:0]}) >> d;
    s = big[31];
    m = (big[31] == sml[31]) ? (mbig + msml) : (mbig - msml);
    if (m == 0) return 33'd0;
    e = eb_i;
    if (m >= (64'd1 << 24)) begin m = m >> 1; e++; end
    while (m < (64'd1 << 23)) begin
      m = m << 1;
      e--;
      if (e <= 0) return 33'd0;
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    return {1'b0, s, e[7:0], m[22:0]};
  endfunction

  // Checker: every cycle, sampled 1 time unit after the rising edge
  initial begin
    logic [32:0] ev;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        last_sum = 32'd0;
        last_ovf = 1'b0;
        checks++;
        if (sum !== 32'd0 || valid !== 1'b0 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL reset_state: sum=%h valid=%b overflow=%b, required 00000000/0/0", sum, valid, overflow);
        end
      end else if (valid === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: sum=%h with no pass outstanding", sum);
        end else begin
          ev = expq.pop_front();
          if ({overflow, sum} !== ev) begin
            errors++;
            $display("FAIL result: sum=%h overflow=%b, required sum=%h overflow=%b", sum, overflow, ev[31:0], ev[32]);
          end
          last_sum = ev[31:0];
          last_ovf = ev[32];
        end
      end else begin
        checks++;
        if (valid !== 1'b0 || sum !== last_sum || overflow !== last_ovf) begin
          errors++;
          $display("FAIL hold: sum=%h valid=%b overflow=%b, required sum=%h valid=0 overflow=%b", sum, valid, overflow, last_sum, last_ovf);
        end
      end
    end
  end

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (valid !== 1'b1 && n < 60);
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: no valid within %0d cycles, required a pulse within 60", tag, n);
    end
  endtask

  initial begin
    va = '{32'h1F00BBF5, 32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h00000000, 32'h4B800000, 32'h7F7FFFFF,
           32'h7F800000, 32'hC0200000, 32'h4C000000, 32'h00800001, 32'h7FC00001, 32'h7F800000, 32'h00000001};
    vb = '{32'h1FFFFFF5, 32'h3F800000, 32'hBF000000, 32'hBF800000, 32'h40490FDB, 32'h3F800000, 32'h7F7FFFFF,
           32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h80800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    ve = '{{1'b0, 32'h20202EF7}, {1'b0, 32'h40000000}, {1'b0, 32'h3F800000}, {1'b0, 32'h00000000},
           {1'b0, 32'h40490FDB}, {1'b0, 32'h4B800000}, {1'b1, 32'h7F800000}, {1'b0, 32'h7FC00000},
           {1'b0, 32'hBFC00000}, {1'b0, 32'h4C000000}, {1'b0, 32'h00000000}, {1'b0, 32'h7FC00000},
           {1'b0, 32'h7F800000}, {1'b0, 32'h3F800000}};

    for (int i = 0; i < N; i++) begin
      logic [32:0] m;
      m = model(va[i], vb[i]);
      checks++;
      if (m !== ve[i]) begin
        errors++;
        $display("FAIL model_pin[%0d]: model gives %h, required %h", i, m, ve[i]);
      end
    end

    // Reset low for two cycles with the first operands already presented
    x = va[0];
    y = vb[0];
    expq.push_back(model(va[0], vb[0]));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_valid("first");

    for (int i = 1; i < N; i++) begin
      x = va[i];
      y = vb[i];
      expq.push_back(model(va[i], vb[i]));
      wait_valid("vec");
    end

    // A 23-step alignment, interrupted by reset while in ALIGN; it reruns after release
    x = 32'h4B000000;
    y = 32'h3F800000;
    expq.push_back(model(x, y));
    repeat (6) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_valid("post_abort");

    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL outstanding: %0d results never delivered, required 0", expq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
